// File: rtl/twos_abs_unit.sv
`default_nettype none
// ============================================================================
//  Module      : twos_abs_unit
//  Description : Registered two's-complement negation and absolute value of a
//                B-bit signed word, with sign / zero / most-negative flags.
//                One cycle of latency, one sample accepted per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module twos_abs_unit #(
  parameter int B        = 12,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [B-1:0] in,
  output logic         out_valid,
  output logic [B-1:0] twos_out,
  output logic [B-1:0] abs_out,
  output logic         neg,
  output logic         zero,
  output logic         ovf
);

  localparam logic [B-1:0] C_ZERO = '0;
  localparam logic [B-1:0] C_ONE  = {{(B-1){1'b0}}, 1'b1};
  localparam logic [B-1:0] C_MIN  = {1'b1, {(B-1){1'b0}}};
  localparam logic [B-1:0] C_MAX  = {1'b0, {(B-1){1'b1}}};

  logic [B-1:0] w_twos;
  logic         w_is_min;
  logic [B-1:0] w_min_abs;

  logic         out_valid_d, out_valid_q;
  logic [B-1:0] twos_d, twos_q;
  logic [B-1:0] abs_d, abs_q;
  logic         neg_d, neg_q;
  logic         zero_d, zero_q;
  logic         ovf_d, ovf_q;

  assign w_twos   = ~in + C_ONE;
  assign w_is_min = (in == C_MIN);

  // The most-negative value has no positive counterpart: either keep the
  // wrapped negation (which is itself) or clamp to the largest positive value.
  generate
    if (SATURATE) begin : g_sat
      assign w_min_abs = C_MAX;
    end else begin : g_wrap
      assign w_min_abs = C_MIN;
    end
  endgenerate

  // Next-state: capture a new result on a valid sample, otherwise hold data.
  always_comb begin
    out_valid_d = in_valid;
    twos_d      = twos_q;
    abs_d       = abs_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      twos_d = w_twos;
      neg_d  = in[B-1];
      zero_d = (in == C_ZERO);
      ovf_d  = w_is_min;
      if (!in[B-1]) begin
        abs_d = in;
      end else if (w_is_min) begin
        abs_d = w_min_abs;
      end else begin
        abs_d = w_twos;
      end
    end
  end

  // Output registers; reset wins over an incoming sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      twos_q      <= C_ZERO;
      abs_q       <= C_ZERO;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      twos_q      <= twos_d;
      abs_q       <= abs_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign twos_out  = twos_q;
  assign abs_out   = abs_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_twos_abs_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twos_abs_unit
//  Description : Self-checking bench for twos_abs_unit. Runs a 12-bit wrapping
//                instance, a 12-bit saturating instance and a 4-bit instance
//                against an integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twos_abs_unit;

  logic clk = 1'b0;
  logic rst;

  // 12-bit instances share stimulus
  logic        in_valid12;
  logic [11:0] in12;
  logic        ov_a, ng_a, zr_a, of_a;
  logic [11:0] tw_a, ab_a;
  logic        ov_b, ng_b, zr_b, of_b;
  logic [11:0] tw_b, ab_b;

  // 4-bit instance
  logic        in_valid4;
  logic [3:0]  in4;
  logic        ov_c, ng_c, zr_c, of_c;
  logic [3:0]  tw_c, ab_c;

  int checks = 0;
  int errors = 0;

  // reference state (what the outputs must show after the next edge)
  logic        e_v,  e_n,  e_z,  e_o;
  logic [11:0] e_tw, e_ab0, e_ab1;
  logic        f_v,  f_n,  f_z,  f_o;
  logic [3:0]  f_tw, f_ab;

  always #5 clk = ~clk;

  twos_abs_unit #(.B(12), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid12), .in(in12),
    .out_valid(ov_a), .twos_out(tw_a), .abs_out(ab_a),
    .neg(ng_a), .zero(zr_a), .ovf(of_a)
  );

  twos_abs_unit #(.B(12), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid12), .in(in12),
    .out_valid(ov_b), .twos_out(tw_b), .abs_out(ab_b),
    .neg(ng_b), .zero(zr_b), .ovf(of_b)
  );

  twos_abs_unit #(.B(4), .SATURATE(1'b0)) dut_b4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in(in4),
    .out_valid(ov_c), .twos_out(tw_c), .abs_out(ab_c),
    .neg(ng_c), .zero(zr_c), .ovf(of_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Arithmetic reference: interpret raw as signed b-bit, negate, take magnitude.
  task automatic ref_model(input int raw, input int b,
                           output int tw, output int ab_wrap, output int ab_sat,
                           output bit n, output bit z, output bit o);
    int m, s, mag;
    m = 1 << b;
    s = (raw >= m / 2) ? raw - m : raw;
    tw = ((-s) % m + m) % m;
    mag = (s < 0) ? -s : s;
    ab_wrap = mag % m;
    ab_sat = (mag > m / 2 - 1) ? m / 2 - 1 : mag;
    n = (s < 0);
    z = (s == 0);
    o = (s == -(m / 2));
  endtask

  // Apply one cycle of stimulus to all instances, then check every output.
  task automatic cycle(input bit r, input bit v, input int x, input bit v4, input int x4);
    int tw, aw, as_;
    bit n, z, o;
    rst        = r;
    in_valid12 = v;
    in12       = x[11:0];
    in_valid4  = v4;
    in4        = x4[3:0];
    if (r) begin
      e_v = 0; e_tw = '0; e_ab0 = '0; e_ab1 = '0; e_n = 0; e_z = 0; e_o = 0;
      f_v = 0; f_tw = '0; f_ab = '0; f_n = 0; f_z = 0; f_o = 0;
    end else begin
      e_v = v;
      if (v) begin
        ref_model(x & 32'hFFF, 12, tw, aw, as_, n, z, o);
        e_tw = tw[11:0]; e_ab0 = aw[11:0]; e_ab1 = as_[11:0];
        e_n = n; e_z = z; e_o = o;
      end
      f_v = v4;
      if (v4) begin
        ref_model(x4 & 32'hF, 4, tw, aw, as_, n, z, o);
        f_tw = tw[3:0]; f_ab = aw[3:0]; f_n = n; f_z = z; f_o = o;
      end
    end
    @(posedge clk);
    #1;
    chk("wrap.valid", {31'd0, ov_a}, {31'd0, e_v});
    chk("wrap.twos",  {20'd0, tw_a}, {20'd0, e_tw});
    chk("wrap.abs",   {20'd0, ab_a}, {20'd0, e_ab0});
    chk("wrap.neg",   {31'd0, ng_a}, {31'd0, e_n});
    chk("wrap.zero",  {31'd0, zr_a}, {31'd0, e_z});
    chk("wrap.ovf",   {31'd0, of_a}, {31'd0, e_o});
    chk("sat.valid",  {31'd0, ov_b}, {31'd0, e_v});
    chk("sat.twos",   {20'd0, tw_b}, {20'd0, e_tw});
    chk("sat.abs",    {20'd0, ab_b}, {20'd0, e_ab1});
    chk("sat.neg",    {31'd0, ng_b}, {31'd0, e_n});
    chk("sat.zero",   {31'd0, zr_b}, {31'd0, e_z});
    chk("sat.ovf",    {31'd0, of_b}, {31'd0, e_o});
    chk("b4.valid",   {31'd0, ov_c}, {31'd0, f_v});
    chk("b4.twos",    {28'd0, tw_c}, {28'd0, f_tw});
    chk("b4.abs",     {28'd0, ab_c}, {28'd0, f_ab});
    chk("b4.neg",     {31'd0, ng_c}, {31'd0, f_n});
    chk("b4.zero",    {31'd0, zr_c}, {31'd0, f_z});
    chk("b4.ovf",     {31'd0, of_c}, {31'd0, f_o});
  endtask

  initial begin
    int stream[5];
    stream = '{1263, -83, -12, 1201, -90};

    // reset held for two cycles while a sample is offered: it is discarded
    cycle(1, 1, 12, 1, 3);
    cycle(1, 1, 12, 1, 3);
    // first sample after release
    cycle(0, 1, 12, 0, 0);
    // hand-derived spot values, independent of the model
    chk("spot.twos12",  {20'd0, tw_a}, 32'hFF4);
    chk("spot.abs12",   {20'd0, ab_a}, 32'd12);

    // back-to-back stream
    foreach (stream[i]) cycle(0, 1, stream[i], 0, 0);
    chk("spot.twos_m90", {20'd0, tw_a}, 32'h05A);

    // zero and most-negative
    cycle(0, 1, 0, 0, 0);
    chk("spot.zero", {31'd0, zr_a}, 32'd1);
    cycle(0, 1, 32'h800, 0, 0);
    chk("spot.abs_wrap", {20'd0, ab_a}, 32'h800);
    chk("spot.abs_sat",  {20'd0, ab_b}, 32'h7FF);
    chk("spot.ovf",      {31'd0, of_a}, 32'd1);

    // hold: one sample of -83, then three idle cycles with junk on the input
    cycle(0, 1, -83, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 5, 0, 0);
    chk("spot.hold_twos", {20'd0, tw_a}, 32'h053);
    chk("spot.hold_abs",  {20'd0, ab_a}, 32'd83);

    // 4-bit exhaustive sweep
    for (int k = 0; k < 16; k++) cycle(0, 0, 0, 1, k);

    // randomized traffic with occasional mid-stream reset and idle cycles
    for (int k = 0; k < 400; k++) begin
      int r12;
      r12 = $urandom_range(0, 4095);
      if (($urandom_range(0, 7)) == 0)
        r12 = ($urandom_range(0, 1) == 1) ? 32'h800 : 0;
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), r12,
            ($urandom_range(0, 1) == 1), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
